// File: rtl/test_i7348_pkg.sv
// Shared widths, trigger constant and stage-1 record for the test_i7348 datapath.
`timescale 1ns/1ps
package test_i7348_pkg;

  localparam int N_W      = 7;
  localparam int CNT_W    = 4;
  localparam int TRIG_MAX = 15;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
  } stage1_t;

  // Combinational term evaluated on the registered stage-1 bits.
  function automatic logic f_term(input stage1_t s);
    return (s.a & ~s.b) | (s.c ^ s.d);
  endfunction

endpackage

// File: rtl/test_i7348_trig.sv
// Saturating count of consecutive all-ones edges; armed once the count tops out.
`timescale 1ns/1ps
module test_i7348_trig
  import test_i7348_pkg::*;
(
  input  logic CK,
  input  logic reset,
  input  logic all_ones,
  output logic armed
);

  localparam logic [CNT_W-1:0] TRIG_MAX_C = CNT_W'(TRIG_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (all_ones) begin
      cnt_d = (cnt_q == TRIG_MAX_C) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign armed = (cnt_q == TRIG_MAX_C);

endmodule

// File: rtl/test_i7348.sv
// Two-stage pipeline: stage-1 logic terms, then Q = f ^ armed registered.
`timescale 1ns/1ps
module test_i7348
  import test_i7348_pkg::*;
(
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic N5,
  input  logic N6,
  input  logic CK,
  input  logic reset,
  output logic Q
);

  logic [N_W-1:0] n_word;
  stage1_t        s1_q;
  stage1_t        s1_d;
  logic           q_q;
  logic           q_d;
  logic           all_ones;
  logic           armed;

  // N0 is the MSB of the stimulus word.
  assign n_word   = {N0, N1, N2, N3, N4, N5, N6};
  assign all_ones = &n_word;

  always_comb begin
    s1_d.a = N0 ^ N1;
    s1_d.b = N2 & N3;
    s1_d.c = N4 | N5;
    s1_d.d = N6;
    q_d    = f_term(s1_q) ^ armed;
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      q_q  <= 1'b0;
    end else begin
      s1_q <= s1_d;
      q_q  <= q_d;
    end
  end

  test_i7348_trig u_trig (
    .CK       (CK),
    .reset    (reset),
    .all_ones (all_ones),
    .armed    (armed)
  );

  assign Q = q_q;

endmodule

// File: tb/tb_test_i7348.sv
// Directed vector table plus hand-written reset/trigger sequences and a half-period sweep.
`timescale 1ns/1ps
module tb_test_i7348;

  logic       ck = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] n = 7'h00;   // n[6] = N0 (MSB) ... n[0] = N6 (LSB)
  logic       q;

  int n_vec  = 0;
  int n_miss = 0;

  always #10 ck = ~ck;

  test_i7348 dut (
    .N0    (n[6]),
    .N1    (n[5]),
    .N2    (n[4]),
    .N3    (n[3]),
    .N4    (n[2]),
    .N5    (n[1]),
    .N6    (n[0]),
    .CK    (ck),
    .reset (reset),
    .Q     (q)
  );

  // Reference model used for the sweep.
  logic       ma, mb, mc, md, mq;
  logic [3:0] mcnt;
  always @(posedge ck or posedge reset) begin
    if (reset) begin
      ma <= 1'b0; mb <= 1'b0; mc <= 1'b0; md <= 1'b0; mq <= 1'b0;
      mcnt <= 4'd0;
    end else begin
      ma   <= n[6] ^ n[5];
      mb   <= n[4] & n[3];
      mc   <= n[2] | n[1];
      md   <= n[0];
      mcnt <= (&n) ? ((mcnt == 4'd15) ? 4'd15 : mcnt + 4'd1) : 4'd0;
      mq   <= ((ma & ~mb) | (mc ^ md)) ^ (mcnt == 4'd15);
    end
  end

  typedef struct {
    logic [6:0] n;
    logic       q_exp;
    string      name;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait k rising edges, then settle on the following falling edge.
  task automatic edges(input int k);
    repeat (k) @(posedge ck);
    @(negedge ck);
  endtask

  initial begin
    tbl[0] = '{7'b1000000, 1'b1, "n1000000"};
    tbl[1] = '{7'b0000001, 1'b1, "n0000001"};
    tbl[2] = '{7'b0000011, 1'b0, "n0000011"};
    tbl[3] = '{7'b1011000, 1'b0, "n1011000"};
    tbl[4] = '{7'b0100000, 1'b1, "n0100000"};
    tbl[5] = '{7'b0011000, 1'b0, "n0011000"};
    tbl[6] = '{7'b0000100, 1'b1, "n0000100"};
    tbl[7] = '{7'b0000000, 1'b0, "n0000000"};
    tbl[8] = '{7'b1100000, 1'b0, "n1100000"};
    tbl[9] = '{7'b1111110, 1'b1, "n1111110"};

    // Reset asserted with all-ones present: state clears without any clock edge.
    n = 7'h7F;
    #1 reset = 1'b1;
    #2;
    check("rst_q_async", {3'b0, q}, 4'd0);
    check("rst_cnt_async", dut.u_trig.cnt_q, 4'd0);
    edges(1);
    check("rst_q_edge_ignored", {3'b0, q}, 4'd0);
    check("rst_cnt_edge_ignored", dut.u_trig.cnt_q, 4'd0);
    reset = 1'b0;

    // Trigger sequence with all-ones held.
    for (int e = 1; e <= 15; e++) begin
      edges(1);
      check($sformatf("trig_edge%0d", e), {3'b0, q}, 4'd0);
    end
    check("trig_cnt15", dut.u_trig.cnt_q, 4'd15);
    for (int e = 16; e <= 18; e++) begin
      edges(1);
      check($sformatf("trig_edge%0d", e), {3'b0, q}, 4'd1);
    end
    check("trig_cnt_sat", dut.u_trig.cnt_q, 4'd15);
    n = 7'b1111110;
    edges(1);
    check("disarm_edge_q", {3'b0, q}, 4'd1);
    check("disarm_cnt", dut.u_trig.cnt_q, 4'd0);
    n = 7'b0000000;
    edges(1);
    check("disarm_next_q", {3'b0, q}, 4'd1);

    // Reset between edges 10 and 11 of an all-ones hold.
    n = 7'h7F;
    edges(10);
    check("pre_rst_cnt10", dut.u_trig.cnt_q, 4'd10);
    #3 reset = 1'b1;
    #1;
    check("midrst_cnt", dut.u_trig.cnt_q, 4'd0);
    check("midrst_q", {3'b0, q}, 4'd0);
    edges(2);
    check("midrst_hold_cnt", dut.u_trig.cnt_q, 4'd0);
    reset = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      edges(1);
      check($sformatf("rearm_edge%0d", e), {3'b0, q}, 4'd0);
    end
    edges(1);
    check("rearm_edge16", {3'b0, q}, 4'd1);

    // Table-driven vectors, each held for two edges.
    for (int i = 0; i < 10; i++) begin
      n = tbl[i].n;
      edges(2);
      check(tbl[i].name, {3'b0, q}, {3'b0, tbl[i].q_exp});
      $display("vec %s N=%b Q=%b exp=%b", tbl[i].name, n, q, tbl[i].q_exp);
    end

    // Sweep: N changes every half period, 5 ns off each clock edge.
    @(negedge ck);
    #5;
    for (int i = 0; i < 128; i++) begin
      n = 7'(i);
      #10;
      $display("N=%b Q=%b", n, q);
      if (i % 2 == 0) check($sformatf("sweep%0d", i), {3'b0, q}, {3'b0, mq});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
